// File: rtl/point_controller.sv
`default_nettype none
// ============================================================================
// point_controller : detects ball exits, runs serve/point/game-over sequencing
//                    and drives the scoreboard's increment_score strobes.
// Revision: 1.0
// ============================================================================
module point_controller #(
   parameter int HRES         = 1280,
   parameter int BALL_W       = 16,
   parameter int SERVE_FRAMES = 60,
   parameter int OVER_FRAMES  = 180
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               fsync,
   input  logic signed [11:0] ball_hpos,
   output logic [1:0]         increment_score,
   output logic               ball_hold,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [3:0]         score0,
   output logic [3:0]         score1,
   output logic               game_over,
   output logic [1:0]         winner
);

   localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  C_SERVE_CNT = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]  C_OVER_CNT  = CNT_W'(OVER_FRAMES);
   localparam logic signed [12:0] C_HRES     = 13'(HRES);
   localparam logic signed [12:0] C_BALL_W   = 13'(BALL_W);
   localparam logic signed [12:0] C_ZERO     = 13'sd0;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       inc_q, inc_d;
   logic             hold_q, hold_d;
   logic             reset_q, reset_d;
   logic             dir_q, dir_d;
   logic [3:0]       score0_q, score0_d;
   logic [3:0]       score1_q, score1_d;
   logic             over_q, over_d;
   logic [1:0]       winner_q, winner_d;
   logic             scorer_q, scorer_d;

   // Sign-extend to 13 bits so hpos + BALL_W cannot wrap.
   logic signed [12:0] w_hpos_ext;
   logic               w_exit_right;
   logic               w_exit_left;
   logic               w_scorer_score_max;

   assign w_hpos_ext         = {ball_hpos[11], ball_hpos};
   assign w_exit_right       = (w_hpos_ext >= C_HRES);
   assign w_exit_left        = ((w_hpos_ext + C_BALL_W) <= C_ZERO);
   assign w_scorer_score_max = scorer_q ? (score1_q == 4'd9) : (score0_q == 4'd9);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      inc_d    = inc_q;
      hold_d   = hold_q;
      reset_d  = 1'b0;
      dir_d    = dir_q;
      score0_d = score0_q;
      score1_d = score1_q;
      over_d   = over_q;
      winner_d = winner_q;
      scorer_d = scorer_q;

      case (state_q)
         ST_SERVE: begin
            hold_d = 1'b1;
            if (fsync) begin
               if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_d = ST_PLAY;
                  hold_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_PLAY: begin
            hold_d = 1'b0;
            if (fsync && (w_exit_right || w_exit_left)) begin
               // Right exit takes priority, so a tie scores for player 0.
               state_d  = ST_POINT;
               hold_d   = 1'b1;
               scorer_d = !w_exit_right;
               inc_d    = w_exit_right ? 2'b01 : 2'b10;
            end
         end
         ST_POINT: begin
            hold_d = 1'b1;
            if (fsync) begin
               inc_d = 2'b00;
               dir_d = !scorer_q;
               if (w_scorer_score_max) begin
                  score0_d = 4'd0;
                  score1_d = 4'd0;
                  over_d   = 1'b1;
                  winner_d = scorer_q ? 2'b10 : 2'b01;
                  state_d  = ST_OVER;
                  cnt_d    = C_OVER_CNT;
               end else begin
                  if (scorer_q) score1_d = score1_q + 4'd1;
                  else          score0_d = score0_q + 4'd1;
                  state_d = ST_SERVE;
                  cnt_d   = C_SERVE_CNT;
                  reset_d = 1'b1;
               end
            end
         end
         ST_OVER: begin
            hold_d = 1'b1;
            if (fsync) begin
               if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_d  = ST_SERVE;
                  cnt_d    = C_SERVE_CNT;
                  over_d   = 1'b0;
                  winner_d = 2'b00;
                  reset_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_SERVE;
            cnt_d   = C_SERVE_CNT;
            hold_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state_q  <= ST_SERVE;
         cnt_q    <= C_SERVE_CNT;
         inc_q    <= 2'b00;
         hold_q   <= 1'b1;
         reset_q  <= 1'b0;
         dir_q    <= 1'b0;
         score0_q <= 4'd0;
         score1_q <= 4'd0;
         over_q   <= 1'b0;
         winner_q <= 2'b00;
         scorer_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         inc_q    <= inc_d;
         hold_q   <= hold_d;
         reset_q  <= reset_d;
         dir_q    <= dir_d;
         score0_q <= score0_d;
         score1_q <= score1_d;
         over_q   <= over_d;
         winner_q <= winner_d;
         scorer_q <= scorer_d;
      end
   end

   assign increment_score = inc_q;
   assign ball_hold       = hold_q;
   assign ball_reset      = reset_q;
   assign serve_dir       = dir_q;
   assign score0          = score0_q;
   assign score1          = score1_q;
   assign game_over       = over_q;
   assign winner          = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_point_controller.sv
`default_nettype none
// Directed bench for point_controller with SERVE_FRAMES=3, OVER_FRAMES=2.
module tb_point_controller;

   logic               pixel_clk = 1'b0;
   logic               rst       = 1'b1;
   logic               fsync     = 1'b0;
   logic signed [11:0] ball_hpos = 12'sd640;
   logic [1:0]         increment_score;
   logic               ball_hold;
   logic               ball_reset;
   logic               serve_dir;
   logic [3:0]         score0;
   logic [3:0]         score1;
   logic               game_over;
   logic [1:0]         winner;

   int n_checks = 0;
   int n_pass   = 0;

   point_controller #(
      .HRES(1280), .BALL_W(16), .SERVE_FRAMES(3), .OVER_FRAMES(2)
   ) dut (
      .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .ball_hpos(ball_hpos),
      .increment_score(increment_score), .ball_hold(ball_hold),
      .ball_reset(ball_reset), .serve_dir(serve_dir), .score0(score0),
      .score1(score1), .game_over(game_over), .winner(winner)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic frame(input logic signed [11:0] pos);
      ball_hpos = pos;
      fsync     = 1'b1;
      tick();
      fsync     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic serve();
      for (int i = 0; i < 3; i++) begin
         frame(12'sd640);
         idle(2);
      end
   endtask

   initial begin
      idle(2);
      rst = 1'b0;
      idle(1);
      check("rst_hold", 16'(ball_hold), 16'd1);
      check("rst_inc", 16'(increment_score), 16'd0);
      check("rst_breset", 16'(ball_reset), 16'd0);
      check("rst_dir", 16'(serve_dir), 16'd0);
      check("rst_scores", {8'd0, score1, score0}, 16'd0);
      check("rst_over", {14'd0, game_over, 1'b0} | 16'(winner), 16'd0);

      // Serve hold lasts exactly three fsyncs
      frame(12'sd640); check("srv_f1_hold", 16'(ball_hold), 16'd1); idle(2);
      frame(12'sd640); check("srv_f2_hold", 16'(ball_hold), 16'd1); idle(2);
      check("srv_inc", 16'(increment_score), 16'd0);
      frame(12'sd640); check("srv_f3_hold", 16'(ball_hold), 16'd0); idle(2);

      // Right exit scores for player 0
      frame(12'sd1280);
      check("p0_inc", 16'(increment_score), 16'd1);
      check("p0_hold", 16'(ball_hold), 16'd1);
      idle(3);
      check("p0_inc_held", 16'(increment_score), 16'd1);
      check("p0_score_pre", 16'(score0), 16'd0);
      frame(12'sd640);
      check("p0_inc_clr", 16'(increment_score), 16'd0);
      check("p0_score", 16'(score0), 16'd1);
      check("p0_breset", 16'(ball_reset), 16'd1);
      check("p0_dir", 16'(serve_dir), 16'd1);
      tick();
      check("p0_breset_off", 16'(ball_reset), 16'd0);
      idle(1);

      // Boundaries, then left exit for player 1
      serve();
      frame(12'sd1279); check("bnd_1279", 16'(increment_score), 16'd0); idle(2);
      frame(-12'sd15);  check("bnd_m15", 16'(increment_score), 16'd0);
      check("bnd_hold", 16'(ball_hold), 16'd0); idle(2);
      frame(-12'sd16);  check("p1_inc", 16'(increment_score), 16'd2); idle(2);
      frame(12'sd640);
      check("p1_score", 16'(score1), 16'd1);
      check("p1_score0", 16'(score0), 16'd1);
      check("p1_dir", 16'(serve_dir), 16'd0);
      idle(2);

      // Out-of-bounds without fsync is ignored
      serve();
      ball_hpos = 12'sd1400;
      idle(3);
      check("nofs_inc", 16'(increment_score), 16'd0);
      frame(12'sd1400);
      check("fs_inc", 16'(increment_score), 16'd1);
      idle(1);
      frame(12'sd640);
      check("fs_score", 16'(score0), 16'd2);
      idle(2);

      // Bring player 0 to 9, then win the game
      for (int k = 0; k < 7; k++) begin
         serve();
         frame(12'sd1280); idle(1);
         frame(12'sd640);  idle(1);
      end
      check("s0_nine", 16'(score0), 16'd9);
      serve();
      frame(12'sd1280); idle(1);
      frame(12'sd640);
      check("go_over", 16'(game_over), 16'd1);
      check("go_winner", 16'(winner), 16'd1);
      check("go_scores", {8'd0, score1, score0}, 16'd0);
      check("go_noreset", 16'(ball_reset), 16'd0);
      idle(2);
      frame(12'sd640);
      check("go_f1_over", 16'(game_over), 16'd1);
      check("go_f1_hold", 16'(ball_hold), 16'd1);
      idle(2);
      frame(12'sd640);
      check("go_end_over", 16'(game_over), 16'd0);
      check("go_end_winner", 16'(winner), 16'd0);
      check("go_end_breset", 16'(ball_reset), 16'd1);
      check("go_end_hold", 16'(ball_hold), 16'd1);
      idle(2);

      // Reset mid-POINT drops the pending increment
      serve();
      frame(12'sd640); idle(1);
      serve();
      frame(-12'sd16);
      check("rp_inc", 16'(increment_score), 16'd2);
      idle(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rp_inc_clr", 16'(increment_score), 16'd0);
      check("rp_hold", 16'(ball_hold), 16'd1);
      check("rp_scores", {8'd0, score1, score0}, 16'd0);
      frame(12'sd640); idle(1);
      frame(12'sd640); check("rp_f2_hold", 16'(ball_hold), 16'd1); idle(1);
      frame(12'sd640); check("rp_f3_hold", 16'(ball_hold), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/point_controller.md
Name: point_controller

Overview:
- Upstream neighbour of the scoreboard; generates its per-player `increment_score` strobes.
- Samples the ball's horizontal position once per frame and detects when the ball leaves the playfield past either edge.
- Runs the serve / point / game-over sequencing and freezes or recenters the ball between rallies.
- Keeps a mirror copy of both scores with the scoreboard's rules (0-9; a point at 9 clears both scores), so it knows when a game ends.

Parameters:
HRES, 1280, playfield width in pixels; the right exit threshold.
BALL_W, 16, ball width in pixels; the left exit threshold is ball_hpos + BALL_W <= 0.
SERVE_FRAMES, 60, frames the ball is held before each serve; must be >= 1.
OVER_FRAMES, 180, frames held in game-over before the next serve; must be >= 1.

Ports:
pixel_clk  in  1  pixel clock.
rst  in  1  synchronous, active-high reset.
fsync  in  1  one-cycle frame-start strobe; all state decisions happen only on cycles where fsync=1.
ball_hpos  in  12 signed  ball left-edge x position; stable across the fsync cycle.
increment_score  out  2  bit i is a point for player i (0 = left player, 1 = right player); level held until consumed.
ball_hold  out  1  1 = the ball engine freezes the ball.
ball_reset  out  1  one-cycle pulse; the ball engine recenters the ball.
serve_dir  out  1  next serve direction: 0 = toward -x (left), 1 = toward +x (right).
score0, score1  out  4 each  mirror scores, 0-9.
game_over  out  1  high while in OVER.
winner  out  2  one-hot winning player; valid while game_over=1, otherwise 0.

Behaviour:
- All registers update on posedge pixel_clk. All outputs are registered.
- Reset values:
  - state=SERVE, cnt=SERVE_FRAMES.
  - increment_score=0, ball_hold=1, ball_reset=0.
  - serve_dir=0, score0=score1=0, game_over=0, winner=0.
- Reset applied in any state, including mid-POINT, aborts everything. Any pending increment is dropped; the scoreboard is reset by the same rst.
- SERVE:
  - ball_hold=1.
  - On fsync: if cnt==1, go to PLAY and set ball_hold=0; otherwise cnt<=cnt-1.
  - The ball is therefore held for exactly SERVE_FRAMES fsync strobes.
- PLAY:
  - ball_hold=0.
  - On fsync, compare in 13-bit signed arithmetic:
    - If ball_hpos >= HRES, the scorer is player 0.
    - Else if ball_hpos + BALL_W <= 0, the scorer is player 1.
    - If both conditions are true, player 0 wins the tie.
  - When a scorer is found: go to POINT, set increment_score[scorer]=1 and ball_hold=1, and latch the scorer.
  - Out-of-bounds positions on non-fsync cycles are ignored.
- POINT:
  - increment_score stays high until the next fsync. The scoreboard samples it on that fsync edge.
  - On that fsync edge, clear increment_score (it is low from the following cycle on). Exactly one fsync ever sees the strobe.
  - Set serve_dir toward the loser: scorer 0 gives serve_dir=1; scorer 1 gives serve_dir=0.
  - If the scorer's mirror score is < 9:
    - Increment that mirror score.
    - Go to SERVE with cnt=SERVE_FRAMES.
    - Pulse ball_reset=1 for one cycle.
  - If the scorer's mirror score == 9:
    - Clear both mirror scores to 0.
    - Set game_over=1 and winner=one-hot(scorer).
    - Go to OVER with cnt=OVER_FRAMES.
- OVER:
  - ball_hold=1.
  - On fsync: if cnt==1, go to SERVE with cnt=SERVE_FRAMES, clear game_over and winner, and pulse ball_reset for one cycle; otherwise cnt<=cnt-1.
- Latency:
  - ball_hpos is sampled at fsync N; increment_score is high from cycle N+1 until the fsync N+1 edge inclusive.
  - The mirror score updates at the fsync N+1 edge, the same edge on which the scoreboard updates its score.
- Counter width: ceil(log2(max(SERVE_FRAMES, OVER_FRAMES)+1)).

Test Plan:
1. Reset; SERVE_FRAMES=3; ball_hpos=640 -> ball_hold=1 through 3 fsyncs; ball_hold=0 the cycle after the 3rd fsync; increment_score=00 throughout.
2. PLAY; ball_hpos=1280 at fsync -> next cycle increment_score=01, ball_hold=1; held until the next fsync; then 00; at that edge score0 goes 0->1, ball_reset pulses for 1 cycle, serve_dir=1.
3. PLAY; ball_hpos=-16 at fsync -> increment_score=10, score1 increments, serve_dir=0. Boundary values 1279 and -15 -> no event.
4. PLAY; ball_hpos=1400 held high on non-fsync cycles only -> no event; the event fires only on the first cycle with fsync=1.
5. score0=9; OVER_FRAMES=2; ball_hpos=1280 -> after the consuming fsync: game_over=1, winner=01, score0=score1=0; 2 fsyncs later game_over=0, winner=00, ball_reset pulses, SERVE begins.
6. rst asserted for 1 cycle while in POINT with increment_score=10 -> the next cycle shows increment_score=00, state SERVE, scores 0, ball_hold=1.
